uart_frame_buffer: RTL and testbench
====================================

Name: uart_frame_buffer

Overview:
Parametrised frame store-and-forward engine between the UART receiver and transmitter. Collects bytes into a frame buffer until DEPTH bytes arrive, a terminator byte arrives, or an inter-byte gap timeout expires. Then it replays the frame to the transmitter, per a selectable mode: echo, reverse, increment or discard. Exposes a debug view port for board LEDs, plus status and frame counters.

Parameters:
DATA_W, 8, byte width of rx/tx data
DEPTH, 8, frame buffer entries (>=2)
ADDR_W, 3, index width, clog2(DEPTH)
USE_TERM, 1, 1 = TERM byte ends a frame (TERM is not stored)
TERM, 8'h0D, terminator value
TIMEOUT, 100000, idle clk cycles in RECV before forced flush; 0 disables

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
rx_valid  in  1  one-cycle pulse from receiver, rx_data valid
rx_data  in  DATA_W  received byte
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
tx_data  out  DATA_W  byte to transmit, stable from tx_start until tx_done
tx_done  in  1  one-cycle pulse from transmitter when byte sent
mode  in  2  00 echo, 01 reverse, 10 increment (+1 mod 2^DATA_W), 11 discard
view_idx  in  ADDR_W  debug read index
view_data  out  DATA_W  buf[view_idx] (combinational); 0 if view_idx>=DEPTH
frame_len  out  ADDR_W+1  length of current/last frame
busy  out  1  state != IDLE
overrun  out  1  sticky: a byte was dropped
frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0.
  - buffer entries, len, tx pointer, gap timer all 0.
- States: IDLE, RECV, SEND_REQ, SEND_WAIT.
- IDLE:
  - rx_valid with TERM match (USE_TERM=1): ignored; empty frames are never sent.
  - Any other rx_valid: buf[0]<=rx_data, len<=1, timer<=0, go RECV.
- RECV:
  - rx_valid non-TERM: buf[len]<=rx_data, len<=len+1, timer<=0. If len+1==DEPTH, go SEND_REQ.
  - rx_valid TERM: go SEND_REQ, len unchanged.
  - No rx_valid: timer++. If TIMEOUT!=0 and timer==TIMEOUT-1, go SEND_REQ.
  - On every exit to SEND_REQ: mode latched into mode_q, ptr<=0. mode changes mid-frame have no effect.
- SEND_REQ:
  - mode_q==11: no transmission; frame_count++, go IDLE.
  - Otherwise, for one cycle: tx_start=1, tx_data=f(buf[idx]), go SEND_WAIT.
  - idx = ptr for echo/increment; idx = len-1-ptr for reverse.
  - f = identity, or +1 with wrap (8'hFF -> 8'h00) for increment.
- SEND_WAIT:
  - tx_data held until tx_done.
  - On tx_done: if ptr+1==len, frame_count++ and go IDLE; else ptr++ and go SEND_REQ.
  - tx_done outside SEND_WAIT is ignored.
- Latency:
  - tx_start is high in the 2nd cycle after the frame-closing rx_valid cycle.
  - Next tx_start is high in the 2nd cycle after each tx_done.
- Boundary conditions:
  - rx_valid in SEND_REQ/SEND_WAIT: byte dropped, overrun<=1 (cleared only by reset).
  - rx_valid and timeout in the same cycle: rx_valid wins; byte stored, timer reset.
  - DEPTH-th byte equal to TERM: treated as terminator, not stored.
  - Buffer contents persist after a frame; view_data shows the last frame.
  - frame_len holds its value until the next frame's first byte.
  - Reset mid-transmit: tx_start drops immediately; no further tx_start until a new frame.

Decomposition:
- Shared package uart_pkg: state encoding constants, mode encodings (MODE_ECHO, MODE_REV, MODE_INC, MODE_DISCARD), default TERM.
- One sub-module: uart_gap_timer.
  - Inputs: clk, rst_n, clear, enable.
  - Output: expire pulse; TIMEOUT parameter, 0 = never expires.

Test Plan:
1. Echo, DEPTH=8: send 11,22..88 -> tx bytes 11,22,33,44,55,66,77,88 in order; frame_count=1; frame_len=8; busy low after last tx_done.
2. Reverse + terminator: mode=01; send 41,42,43,0D -> tx 43,42,41; frame_len=3; 0D never transmitted.
3. Increment wrap: mode=10; send FF,00,7F,0D -> tx 00,01,80.
4. Timeout: TIMEOUT=50; send 5A,A5, then idle -> flush at the 50th idle cycle; tx 5A,A5; a lone 0D in IDLE produces no tx and frame_count is unchanged.
5. Overrun and discard:
   - Send 3C during SEND_WAIT -> overrun=1 and stays set.
   - Next frame with mode=11 -> no tx_start; frame_count increments.
6. Async reset during SEND_WAIT of byte 2:
   - tx_start=0, busy=0, frame_count=0, view_data=0 for all idx, with no clock edge.
   - A new frame after release is echoed correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame buffer: FSM states, replay modes and
// the default frame terminator.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RECV      = 2'b01,
    ST_SEND_REQ  = 2'b10,
    ST_SEND_WAIT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_ECHO    = 2'b00,
    MODE_REV     = 2'b01,
    MODE_INC     = 2'b10,
    MODE_DISCARD = 2'b11
  } mode_t;

  localparam logic [7:0] DEFAULT_TERM = 8'h0D;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled idle cycles since the last clear and
// pulses expire on the TIMEOUT-th one. TIMEOUT = 0 never expires.
module uart_gap_timer #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a disabled or stalled timer never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/uart_frame_buffer.sv
// Frame store-and-forward between UART rx and tx: gathers a frame (full,
// terminator or gap timeout), then replays it as echo/reverse/increment/discard.
module uart_frame_buffer
  import uart_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       DEPTH    = 8,
  parameter int unsigned       ADDR_W   = 3,
  parameter bit                USE_TERM = 1'b1,
  parameter logic [DATA_W-1:0] TERM     = DATA_W'(DEFAULT_TERM),
  parameter int unsigned       TIMEOUT  = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] view_idx,
  output logic [DATA_W-1:0] view_data,
  output logic [ADDR_W:0]   frame_len,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_count
);

  localparam int unsigned LW = ADDR_W + 1;

  state_t              state, state_nxt;
  mode_t               mode_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]     len;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   rev_idx, tx_idx, wr_addr;
  logic [DATA_W-1:0]   tx_raw;
  logic                is_term, byte_ok, full_next, last_byte;
  logic                expire, closing, store, frame_done, sending;

  assign is_term   = USE_TERM && (rx_data == TERM);
  assign byte_ok   = rx_valid && !is_term;
  assign full_next = (len + 1'b1) == LW'(DEPTH);
  assign last_byte = (LW'(ptr) + 1'b1) == len;
  assign sending   = (state == ST_SEND_REQ) || (state == ST_SEND_WAIT);

  uart_gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rx_valid || (state != ST_RECV)),
    .enable((state == ST_RECV) && !rx_valid),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (byte_ok) state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (is_term || full_next) state_nxt = ST_SEND_REQ;
        end else if (expire) begin
          state_nxt = ST_SEND_REQ;
        end
      end
      ST_SEND_REQ: begin
        state_nxt = (mode_q == MODE_DISCARD) ? ST_IDLE : ST_SEND_WAIT;
      end
      ST_SEND_WAIT: begin
        if (tx_done) state_nxt = last_byte ? ST_IDLE : ST_SEND_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign closing    = (state == ST_RECV) && (state_nxt == ST_SEND_REQ);
  assign store      = byte_ok && ((state == ST_IDLE) || (state == ST_RECV));
  assign wr_addr    = (state == ST_IDLE) ? '0 : len[ADDR_W-1:0];
  assign frame_done = ((state == ST_SEND_REQ) && (mode_q == MODE_DISCARD)) ||
                      ((state == ST_SEND_WAIT) && tx_done && last_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store) begin
      mem[wr_addr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len         <= '0;
      ptr         <= '0;
      mode_q      <= MODE_ECHO;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      if (store) len <= (state == ST_IDLE) ? LW'(1) : len + 1'b1;
      if (closing) begin
        mode_q <= mode_t'(mode);
        ptr    <= '0;
      end else if ((state == ST_SEND_WAIT) && tx_done && !last_byte) begin
        ptr <= ptr + 1'b1;
      end
      if (rx_valid && sending) overrun <= 1'b1;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

  // len[ADDR_W-1:0] wraps to 0 for a full power-of-two frame; modulo math still yields len-1-ptr.
  assign rev_idx = len[ADDR_W-1:0] - ptr - 1'b1;
  assign tx_idx  = (mode_q == MODE_REV) ? rev_idx : ptr;
  assign tx_raw  = mem[tx_idx];

  assign tx_start  = (state == ST_SEND_REQ) && (mode_q != MODE_DISCARD);
  assign tx_data   = !sending ? '0 :
                     (mode_q == MODE_INC) ? tx_raw + DATA_W'(1) : tx_raw;
  assign view_data = (LW'(view_idx) < LW'(DEPTH)) ? mem[view_idx] : '0;
  assign frame_len = len;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Self-checking bench for uart_frame_buffer: frame-level reference model,
// per-cycle compare process, directed cases plus randomized frames.
module tb_uart_frame_buffer;

  localparam int DEPTH = 8;
  localparam int TMO   = 50;
  localparam logic [7:0] TERMB = 8'h0D;
  localparam int K_TERM = 0, K_FULL = 1, K_TMO = 2;

  logic       clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic [1:0] mode = '0;
  logic [2:0] view_idx = '0;
  logic       tx_start, busy, overrun;
  logic [7:0] tx_data, view_data;
  logic [3:0] frame_len;
  logic [15:0] frame_count;

  uart_frame_buffer #(
    .DATA_W(8), .DEPTH(DEPTH), .ADDR_W(3), .USE_TERM(1'b1), .TERM(TERMB), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .mode(mode),
    .view_idx(view_idx), .view_data(view_data), .frame_len(frame_len),
    .busy(busy), .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [7:0] model_buf [DEPTH];
  int         model_fc = 0;
  bit         model_ovr = 0;
  logic [7:0] fr [DEPTH];
  logic [7:0] exp_q[$], log_q[$], lit[$];
  bit         tx_pending = 0, chk_next_start = 0, chk_idle_now = 0, view_rand = 0;
  logic [7:0] tx_hold;
  int         tx_delay = 0, tx_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: view port, tx bytes against the expected queue, hold and latency.
  always @(negedge clk) begin
    chk("view_data", view_data, model_buf[view_idx]);
    if (!rst_n) begin
      tx_pending = 0; chk_next_start = 0; chk_idle_now = 0;
    end else begin
      if (chk_next_start) begin chk("tx_start_after_done", tx_start, 1); chk_next_start = 0; end
      if (chk_idle_now)   begin chk("busy_after_last_done", busy, 0);    chk_idle_now = 0;   end
      if (tx_start) begin
        tx_seen++;
        chk("tx_start_while_pending", tx_pending, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got tx_start with tx_data=%0h, required no tx_start", tx_data);
        end else begin
          chk("tx_data", tx_data, exp_q.pop_front());
        end
        log_q.push_back(tx_data);
        tx_hold = tx_data; tx_pending = 1; tx_delay = $urandom_range(0, 3);
      end else if (tx_pending) begin
        chk("tx_data_hold", tx_data, tx_hold);
      end
    end
  end

  // Transmitter model: answers each tx_start with a one-cycle tx_done after a random delay.
  initial forever begin
    @(posedge clk); #1;
    if (tx_done) begin
      tx_done = 0; tx_pending = 0;
      if (rst_n) begin
        if (exp_q.size() > 0) chk_next_start = 1;
        else                  chk_idle_now = 1;
      end
    end else if (tx_pending && rst_n) begin
      if (tx_delay > 0) tx_delay--;
      else tx_done = 1;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (view_rand) view_idx = 3'($urandom_range(0, 7));
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1; tick(); rx_valid = 0;
  endtask

  task automatic load_fr();
    for (int i = 0; i < lit.size(); i++) fr[i] = lit[i];
  endtask

  task automatic push_expected(input int n, input logic [1:0] m);
    logic [7:0] v;
    if (m == 2'b11) return;
    for (int i = 0; i < n; i++) begin
      v = (m == 2'b01) ? fr[n-1-i] : fr[i];
      if (m == 2'b10) v = v + 8'd1;
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 3000) begin @(negedge clk); k++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", k);
    end
  endtask

  task automatic send_frame_open(input int n, input logic [1:0] m, input int kind, input int gap);
    int g;
    mode = m;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        g = (gap < 0) ? $urandom_range(0, 4) : gap;
        repeat (g) tick();
      end
      if (i == n - 1 && kind == K_FULL) push_expected(n, m);
      send_byte(fr[i]);
      model_buf[i] = fr[i];
    end
    if (kind == K_TERM) begin
      push_expected(n, m);
      send_byte(TERMB);
    end else if (kind == K_TMO) begin
      push_expected(n, m);
      repeat (TMO - 1) tick();
      @(negedge clk);
      chk("tx_start_before_timeout", tx_start, 0);
      tick();
    end
    @(negedge clk);
    chk("close_latency", tx_start, (m != 2'b11));
    chk("busy_after_close", busy, 1);
    mode = 2'($urandom);
  endtask

  task automatic finish_frame(input int n);
    wait_idle();
    model_fc++;
    chk("frame_count", frame_count, 16'(model_fc));
    chk("frame_len", frame_len, n);
    chk("overrun", overrun, model_ovr);
    chk("all_tx_sent", exp_q.size(), 0);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, log_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < log_q.size(); i++) chk(name, log_q[i], lit[i]);
    log_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, n, kind;
    logic [1:0] m;
    logic [7:0] v;
    foreach (model_buf[i]) model_buf[i] = '0;

    #3;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_frame_count", frame_count, 0);
    #10 rst_n = 1;
    view_rand = 1;
    tick();

    // Echo, full frame
    lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}; load_fr();
    send_frame_open(8, 2'b00, K_FULL, -1); finish_frame(8);
    check_log("echo");

    // Reverse with terminator
    lit = '{8'h41, 8'h42, 8'h43}; load_fr();
    send_frame_open(3, 2'b01, K_TERM, -1); finish_frame(3);
    lit = '{8'h43, 8'h42, 8'h41}; check_log("reverse");

    // Increment with wrap
    lit = '{8'hFF, 8'h00, 8'h7F}; load_fr();
    send_frame_open(3, 2'b10, K_TERM, -1); finish_frame(3);
    lit = '{8'h00, 8'h01, 8'h80}; check_log("increment");

    // Gap timeout flush
    lit = '{8'h5A, 8'hA5}; load_fr();
    send_frame_open(2, 2'b00, K_TMO, -1); finish_frame(2);
    check_log("timeout");

    // Lone terminator in IDLE
    send_byte(TERMB);
    repeat (3) @(negedge clk);
    chk("lone_term_busy", busy, 0);
    chk("lone_term_count", frame_count, 16'(model_fc));
    chk("lone_term_len", frame_len, 2);

    // Byte arriving on the expiring cycle is kept
    lit = '{8'h61, 8'h62}; load_fr();
    send_frame_open(2, 2'b00, K_TERM, TMO - 1); finish_frame(2);
    check_log("rx_vs_timeout");

    // DEPTH-th byte is a terminator
    lit = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}; load_fr();
    send_frame_open(7, 2'b00, K_TERM, -1); finish_frame(7);
    check_log("term_at_depth");

    // Overrun during transmit, then a discarded frame
    lit = '{8'hC1, 8'hC2, 8'hC3}; load_fr();
    send_frame_open(3, 2'b00, K_TERM, -1);
    send_byte(8'h3C);
    model_ovr = 1;
    @(negedge clk); chk("overrun_set", overrun, 1);
    finish_frame(3);
    log_q.delete();
    lit = '{8'hD1, 8'hD2}; load_fr();
    send_frame_open(2, 2'b11, K_TERM, -1); finish_frame(2);
    chk("discard_no_tx", log_q.size(), 0);

    // Async reset while waiting on byte 2
    lit = '{8'h71, 8'h72, 8'h73, 8'h74}; load_fr();
    base = tx_seen;
    send_frame_open(4, 2'b00, K_TERM, -1);
    k = 0;
    while (tx_seen < base + 2 && k < 200) begin @(negedge clk); #1; k++; end
    chk("reached_byte2", tx_seen >= base + 2, 1);
    @(negedge clk); #2;
    view_rand = 0;
    rst_n = 0; tx_done = 0; tx_pending = 0; chk_next_start = 0; chk_idle_now = 0;
    foreach (model_buf[i]) model_buf[i] = '0;
    exp_q.delete(); log_q.delete();
    model_fc = 0; model_ovr = 0;
    #1;
    chk("arst_tx_start", tx_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_overrun", overrun, 0);
    for (int i = 0; i < DEPTH; i++) begin
      view_idx = 3'(i); #1;
      chk("arst_view_data", view_data, 0);
    end
    @(negedge clk); #2 rst_n = 1;
    view_rand = 1;
    tick();
    lit = '{8'h81, 8'h82, 8'h83}; load_fr();
    send_frame_open(3, 2'b00, K_TERM, -1); finish_frame(3);
    check_log("after_reset");

    // Randomized frames
    repeat (25) begin
      kind = $urandom_range(0, 2);
      n = (kind == K_FULL) ? DEPTH : $urandom_range(1, DEPTH - 1);
      m = 2'($urandom);
      for (int i = 0; i < n; i++) begin
        v = 8'($urandom);
        if (v == TERMB) v = 8'h0E;
        fr[i] = v;
      end
      send_frame_open(n, m, kind, -1);
      finish_frame(n);
      log_q.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
